// File: rtl/cpu7_ifu_fbuf.sv
// ---------------------------------------------------------------------------
// cpu7_ifu_fbuf
// Fetch buffer between the instruction fetch unit and the decode stage.
// Fetched instructions are queued together with their sideband fields. The
// oldest entry is presented on de_port0_* at a rate of one per cycle. A
// downstream stall holds the head entry, and a flush empties the buffer.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   fe_valid            fetch presents an instruction this cycle
//   fe_pc .. fe_hint    instruction and sideband written on push
//   fe_ready            buffer not full (registered state only)
//   de_stall            decode cannot accept an instruction
//   flush               empties the buffer; same-cycle fetch is discarded
//   de_port0_valid      head entry issued (popped) this cycle
//   de_port0_pc .. hint head entry fields, shown even while invalid
//   fb_count            occupied entries
//   fb_overflow         sticky: fetch presented while buffer full
// ---------------------------------------------------------------------------
module cpu7_ifu_fbuf #(
    parameter int DEPTH  = 4,
    parameter int GRLEN  = 32,
    parameter int HINT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fe_valid,
    input  logic [GRLEN-1:0]        fe_pc,
    input  logic [31:0]             fe_inst,
    input  logic [GRLEN-3:0]        fe_br_target,
    input  logic                    fe_br_taken,
    input  logic                    fe_exception,
    input  logic [5:0]              fe_exccode,
    input  logic [HINT_W-1:0]       fe_hint,
    output logic                    fe_ready,
    input  logic                    de_stall,
    input  logic                    flush,
    output logic                    de_port0_valid,
    output logic [GRLEN-1:0]        de_port0_pc,
    output logic [31:0]             de_port0_inst,
    output logic [GRLEN-3:0]        de_port0_br_target,
    output logic                    de_port0_br_taken,
    output logic                    de_port0_exception,
    output logic [5:0]              de_port0_exccode,
    output logic [HINT_W-1:0]       de_port0_hint,
    output logic [$clog2(DEPTH):0]  fb_count,
    output logic                    fb_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic               fb_overflow_q, fb_overflow_d;

    // Entry storage; contents are never reset.
    logic [GRLEN-1:0]   pc_q       [DEPTH];
    logic [31:0]        inst_q     [DEPTH];
    logic [GRLEN-3:0]   br_tgt_q   [DEPTH];
    logic               br_taken_q [DEPTH];
    logic               exc_q      [DEPTH];
    logic [5:0]         exccode_q  [DEPTH];
    logic [HINT_W-1:0]  hint_q     [DEPTH];

    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      wr_idx;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];
    assign empty  = (rd_ptr_q == wr_ptr_q);
    assign full   = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

    // fe_ready looks only at registered state, so a same-cycle pop never
    // opens a slot for the same-cycle fetch.
    assign fe_ready = !full;
    assign push     = fe_valid && !full && !flush;
    assign pop      = !empty && !de_stall && !flush;

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fb_overflow_d = fb_overflow_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            // A flush discards fetch silently; only a genuine full drop counts.
            if (fe_valid && full) fb_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fb_overflow_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fb_overflow_q <= fb_overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_idx]       <= fe_pc;
            inst_q[wr_idx]     <= fe_inst;
            br_tgt_q[wr_idx]   <= fe_br_target;
            br_taken_q[wr_idx] <= fe_br_taken;
            exc_q[wr_idx]      <= fe_exception;
            exccode_q[wr_idx]  <= fe_exccode;
            hint_q[wr_idx]     <= fe_hint;
        end
    end

    assign de_port0_valid     = pop;
    assign de_port0_pc        = pc_q[rd_idx];
    assign de_port0_inst      = inst_q[rd_idx];
    assign de_port0_br_target = br_tgt_q[rd_idx];
    assign de_port0_br_taken  = br_taken_q[rd_idx];
    assign de_port0_exception = exc_q[rd_idx];
    assign de_port0_exccode   = exccode_q[rd_idx];
    assign de_port0_hint      = hint_q[rd_idx];

    // Pointer difference modulo 2*DEPTH is the occupancy.
    assign fb_count    = wr_ptr_q - rd_ptr_q;
    assign fb_overflow = fb_overflow_q;

endmodule

// File: tb/tb_cpu7_ifu_fbuf.sv
// ---------------------------------------------------------------------------
// tb_cpu7_ifu_fbuf
// Self-checking bench for cpu7_ifu_fbuf. The stimulus process keeps an
// occupancy/overflow model and queues each accepted instruction on a
// scoreboard. A monitor on the falling edge checks the status outputs and
// pops the scoreboard for every instruction issued to decode.
// ---------------------------------------------------------------------------
module tb_cpu7_ifu_fbuf;

    localparam int DEPTH  = 4;
    localparam int GRLEN  = 32;
    localparam int HINT_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [29:0] tgt;
        logic        taken;
        logic        exc;
        logic [5:0]  exccode;
        logic [3:0]  hint;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              fe_valid;
    logic [31:0]       fe_pc;
    logic [31:0]       fe_inst;
    logic [29:0]       fe_br_target;
    logic              fe_br_taken;
    logic              fe_exception;
    logic [5:0]        fe_exccode;
    logic [3:0]        fe_hint;
    logic              fe_ready;
    logic              de_stall;
    logic              flush;
    logic              de_port0_valid;
    logic [31:0]       de_port0_pc;
    logic [31:0]       de_port0_inst;
    logic [29:0]       de_port0_br_target;
    logic              de_port0_br_taken;
    logic              de_port0_exception;
    logic [5:0]        de_port0_exccode;
    logic [3:0]        de_port0_hint;
    logic [2:0]        fb_count;
    logic              fb_overflow;

    cpu7_ifu_fbuf #(.DEPTH(DEPTH), .GRLEN(GRLEN), .HINT_W(HINT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .fe_valid           (fe_valid),
        .fe_pc              (fe_pc),
        .fe_inst            (fe_inst),
        .fe_br_target       (fe_br_target),
        .fe_br_taken        (fe_br_taken),
        .fe_exception       (fe_exception),
        .fe_exccode         (fe_exccode),
        .fe_hint            (fe_hint),
        .fe_ready           (fe_ready),
        .de_stall           (de_stall),
        .flush              (flush),
        .de_port0_valid     (de_port0_valid),
        .de_port0_pc        (de_port0_pc),
        .de_port0_inst      (de_port0_inst),
        .de_port0_br_target (de_port0_br_target),
        .de_port0_br_taken  (de_port0_br_taken),
        .de_port0_exception (de_port0_exception),
        .de_port0_exccode   (de_port0_exccode),
        .de_port0_hint      (de_port0_hint),
        .fb_count           (fb_count),
        .fb_overflow        (fb_overflow)
    );

    always #5 clk = ~clk;

    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: number of buffered entries and sticky overflow.
    int   occ       = 0;
    bit   ovf       = 1'b0;
    bit   clr_pend  = 1'b0;
    bit   chk_en    = 1'b0;
    bit   exp_valid = 1'b0;
    bit   exp_ready = 1'b1;
    bit   exp_ovf   = 1'b0;
    int   exp_count = 0;

    function automatic ent_t rnd_ent();
        ent_t e;
        e.pc      = $urandom;
        e.inst    = $urandom;
        e.tgt     = 30'($urandom);
        e.taken   = 1'($urandom);
        e.exc     = 1'($urandom);
        e.exccode = 6'($urandom);
        e.hint    = 4'($urandom);
        return e;
    endfunction

    // One clock cycle of stimulus; the expected status for this cycle comes
    // from the model state at the start of the cycle.
    task automatic step(input bit r, input bit v, input bit s, input bit f, input ent_t e);
        bit acc;
        @(posedge clk);
        #1;
        if (clr_pend) begin
            sb.delete();
            clr_pend = 1'b0;
        end
        rst          = r;
        fe_valid     = v;
        de_stall     = s;
        flush        = f;
        fe_pc        = e.pc;
        fe_inst      = e.inst;
        fe_br_target = e.tgt;
        fe_br_taken  = e.taken;
        fe_exception = e.exc;
        fe_exccode   = e.exccode;
        fe_hint      = e.hint;
        exp_count = occ;
        exp_ready = (occ < DEPTH);
        exp_valid = (occ > 0) && !s && !f;
        exp_ovf   = ovf;
        chk_en    = 1'b1;
        if (r) begin
            occ = 0;
            ovf = 1'b0;
            clr_pend = 1'b1;
        end else if (f) begin
            occ = 0;
            clr_pend = 1'b1;
        end else begin
            acc = v && (occ < DEPTH);
            if (v && !acc) ovf = 1'b1;
            if (acc) sb.push_back(e);
            occ = occ + int'(acc) - int'(exp_valid);
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: status outputs every cycle, entry contents on every issue.
    always @(negedge clk) begin
        if (chk_en) begin
            ent_t got;
            ent_t want;
            check("de_port0_valid", longint'(de_port0_valid), longint'(exp_valid));
            check("fb_count", longint'(fb_count), longint'(exp_count));
            check("fe_ready", longint'(fe_ready), longint'(exp_ready));
            check("fb_overflow", longint'(fb_overflow), longint'(exp_ovf));
            if (de_port0_valid) begin
                got = '{pc: de_port0_pc, inst: de_port0_inst, tgt: de_port0_br_target,
                        taken: de_port0_br_taken, exc: de_port0_exception,
                        exccode: de_port0_exccode, hint: de_port0_hint};
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_unexpected: got pc 0x%0h, expected no issue", de_port0_pc);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL issue_entry: got 0x%0h, expected 0x%0h", got, want);
                    end
                end
            end
        end
    end

    initial begin
        ent_t e;
        rst = 1'b1; fe_valid = 1'b0; de_stall = 1'b0; flush = 1'b0;
        fe_pc = '0; fe_inst = '0; fe_br_target = '0; fe_br_taken = 1'b0;
        fe_exception = 1'b0; fe_exccode = '0; fe_hint = '0;
        repeat (2) @(posedge clk);

        // Single push after reset, issued the following cycle.
        e = rnd_ent(); e.pc = 32'h1c00_0000; e.inst = 32'h0280_0421;
        step(0, 1, 0, 0, e);
        step(0, 0, 0, 0, rnd_ent());
        step(0, 0, 0, 0, rnd_ent());

        // Fill under stall, overflow attempt, then drain in order.
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, rnd_ent());
        step(0, 1, 1, 0, rnd_ent());
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, rnd_ent());

        // Streaming push+pop with sequential pcs across two pointer wraps.
        step(1, 0, 0, 0, rnd_ent());
        e = rnd_ent(); e.pc = 32'h1c00_1000;
        for (int i = 0; i < 11; i++) begin
            step(0, 1, 0, 0, e);
            e = rnd_ent(); e.pc = 32'h1c00_1004 + 32'(4 * i);
        end
        step(0, 0, 0, 0, rnd_ent());
        step(0, 0, 0, 0, rnd_ent());

        // Flush with three entries held and fetch valid in the same cycle.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, rnd_ent());
        step(0, 1, 0, 1, rnd_ent());
        step(0, 0, 0, 0, rnd_ent());

        // Exception entry with all sideband fields set.
        e.pc = 32'h1c00_2000; e.inst = 32'h0000_002b; e.tgt = 30'h0700_0010;
        e.taken = 1'b1; e.exc = 1'b1; e.exccode = 6'h08; e.hint = 4'hA;
        step(0, 1, 0, 0, e);
        step(0, 0, 0, 0, rnd_ent());

        // Reset with two entries held and decode not stalled.
        step(0, 1, 1, 0, rnd_ent());
        step(0, 1, 1, 0, rnd_ent());
        step(1, 0, 0, 0, rnd_ent());
        step(0, 0, 0, 0, rnd_ent());

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
                 ($urandom % 25) == 0, rnd_ent());
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, rnd_ent());

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
